// File: rtl/result_packet_encoder.sv
// Serialises one latched mining result as a framed byte stream:
// sync, status, nonce (LE), optional hash (LE), XOR checksum.
module result_packet_encoder #(
   parameter logic [7:0] SYNC_BYTE  = 8'h5A,
   parameter int         HASH_BYTES = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    long_mode,
   input  logic                    found,
   input  logic [31:0]             nonce,
   input  logic [HASH_BYTES*8-1:0] hash,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    busy,
   output logic                    packet_done
);

   // Handshake: a byte moves on any cycle with tx_valid && tx_ready; while
   // tx_valid is high and tx_ready low, tx_data and tx_valid hold steady.

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_STATUS, S_NONCE, S_HASH, S_CSUM, S_DONE
   } state_t;

   localparam logic [5:0] NONCE_LAST = 6'd3;
   localparam logic [5:0] HASH_LAST  = 6'(HASH_BYTES - 1);

   state_t                  state, state_nxt;
   logic [5:0]              idx;
   logic                    long_q, found_q;
   logic [31:0]             nonce_q;
   logic [HASH_BYTES*8-1:0] hash_q;
   logic [7:0]              csum_q;
   logic                    xfer;
   logic                    accept;

   assign xfer   = tx_valid && tx_ready;
   assign accept = (state == S_IDLE) && start;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_SYNC;
         S_SYNC:   if (xfer)  state_nxt = S_STATUS;
         S_STATUS: if (xfer)  state_nxt = S_NONCE;
         S_NONCE:  if (xfer && idx == NONCE_LAST) state_nxt = long_q ? S_HASH : S_CSUM;
         S_HASH:   if (xfer && idx == HASH_LAST)  state_nxt = S_CSUM;
         S_CSUM:   if (xfer)  state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      tx_data     = 8'h00;
      tx_valid    = 1'b0;
      busy        = (state != S_IDLE);
      packet_done = (state == S_DONE);
      case (state)
         S_SYNC: begin
            tx_valid = 1'b1;
            tx_data  = SYNC_BYTE;
         end
         S_STATUS: begin
            tx_valid = 1'b1;
            tx_data  = {6'b0, long_q, found_q};
         end
         S_NONCE: begin
            tx_valid = 1'b1;
            tx_data  = nonce_q[{idx[1:0], 3'b000} +: 8];
         end
         S_HASH: begin
            tx_valid = 1'b1;
            tx_data  = hash_q[{idx, 3'b000} +: 8];
         end
         S_CSUM: begin
            tx_valid = 1'b1;
            tx_data  = csum_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         idx     <= '0;
         long_q  <= 1'b0;
         found_q <= 1'b0;
         nonce_q <= '0;
         hash_q  <= '0;
         csum_q  <= '0;
      end else begin
         state <= state_nxt;
         // Index restarts on every state change so each field counts from 0.
         if (state_nxt != state)
            idx <= '0;
         else if (xfer)
            idx <= idx + 6'd1;
         if (accept) begin
            long_q  <= long_mode;
            found_q <= found;
            nonce_q <= nonce;
            hash_q  <= hash;
            csum_q  <= '0;
         end else if (xfer && state != S_CSUM) begin
            csum_q <= csum_q ^ tx_data;
         end
      end
   end

   stall_holds_data: assert property (@(posedge clk) disable iff (rst)
      (tx_valid && !tx_ready) |=> (tx_valid && $stable(tx_data)));
   done_single_pulse: assert property (@(posedge clk) disable iff (rst)
      packet_done |=> !packet_done);

endmodule

// File: tb/tb_result_packet_encoder.sv
// Bench for result_packet_encoder: frame-level reference model with a
// per-cycle compare process, directed scenarios and randomized frames.
module tb_result_packet_encoder;
   localparam int HB = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          long_mode = 1'b0;
   logic          found = 1'b0;
   logic [31:0]   nonce = '0;
   logic [HB*8-1:0] hash = '0;
   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b1;
   logic          busy;
   logic          packet_done;

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q[$];
   logic [7:0] rx_log[$];
   logic m_busy = 1'b0;
   logic m_done = 1'b0;
   int   m_xfers = 0;
   bit   chk_en = 1'b0;
   int   rdy_mode = 0;

   result_packet_encoder #(.SYNC_BYTE(8'h5A), .HASH_BYTES(HB)) dut (
      .clk(clk), .rst(rst), .start(start), .long_mode(long_mode), .found(found),
      .nonce(nonce), .hash(hash), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .packet_done(packet_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Whole frame computed from the inputs seen at the accepting edge.
   function automatic void build_frame();
      logic [7:0] b[$];
      logic [7:0] c;
      b.push_back(8'h5A);
      b.push_back({6'b0, long_mode, found});
      for (int i = 0; i < 4; i++) b.push_back(nonce[8*i +: 8]);
      if (long_mode) for (int i = 0; i < HB; i++) b.push_back(hash[8*i +: 8]);
      c = 8'h00;
      foreach (b[i]) c = c ^ b[i];
      b.push_back(c);
      exp_q = b;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_xfers <= 0;
      end else if (m_done) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
      end else if (!m_busy) begin
         if (start) begin
            build_frame();
            m_busy  <= 1'b1;
            m_xfers <= 0;
         end
      end else if (tx_ready && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         m_xfers <= m_xfers + 1;
         if (exp_q.size() == 0) m_done <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic m_valid;
         m_valid = m_busy && !m_done && exp_q.size() > 0;
         check("tx_valid", tx_valid, m_valid);
         check("busy", busy, m_busy);
         check("packet_done", packet_done, m_done);
         if (m_valid) check("tx_data", tx_data, exp_q[0]);
         else if (!m_busy) check("tx_data_idle", tx_data, 0);
         if (tx_valid && tx_ready) rx_log.push_back(tx_data);
      end
   end

   always begin
      @(posedge clk);
      #1;
      tx_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic lm, input logic fd, input logic [31:0] n, input logic [HB*8-1:0] h);
      long_mode = lm;
      found = fd;
      nonce = n;
      hash = h;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int n);
      n = 0;
      while (!packet_done && n < bound) begin
         tick();
         n++;
      end
      check("frame_end_seen", packet_done, 1);
   endtask

   function automatic logic [HB*8-1:0] rand_hash();
      logic [HB*8-1:0] h;
      for (int i = 0; i < HB / 4; i++) h[32*i +: 32] = $urandom;
      return h;
   endfunction

   initial begin
      logic [7:0] lit_short [7];
      logic [7:0] lit_c [7];
      int n;
      int nz;
      logic [HB*8-1:0] h6;

      lit_short = '{8'h5A, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h53};
      lit_c     = '{8'h5A, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h5A};

      // Reset and idle
      tick(); tick();
      chk_en = 1'b1;
      check("rst_busy", busy, 0);
      check("rst_valid", tx_valid, 0);
      check("rst_data", tx_data, 0);
      rst = 1'b0;
      repeat (5) tick();
      check("idle_done", packet_done, 0);

      // Short frame, ready held high
      rx_log.delete();
      send(1'b0, 1'b1, 32'h12345678, '0);
      check("short_first_valid", tx_valid, 1);
      check("short_first_byte", tx_data, 8'h5A);
      wait_done(50, n);
      check("short_cycles", n, 7);
      check("short_len", rx_log.size(), 7);
      for (int i = 0; i < 7 && i < rx_log.size(); i++) check("short_byte", rx_log[i], lit_short[i]);
      tick();
      check("short_idle_busy", busy, 0);

      // Long frame of zeros
      rx_log.delete();
      send(1'b1, 1'b0, 32'h0, '0);
      wait_done(100, n);
      check("long_cycles", n, 39);
      check("long_len", rx_log.size(), 39);
      if (rx_log.size() == 39) begin
         check("long_sync", rx_log[0], 8'h5A);
         check("long_status", rx_log[1], 8'h02);
         check("long_csum", rx_log[38], 8'h58);
         nz = 0;
         for (int i = 2; i < 38; i++) if (rx_log[i] != 8'h00) nz++;
         check("long_zero_payload", nz, 0);
      end
      tick();

      // Short frame with random back-pressure
      rx_log.delete();
      rdy_mode = 1;
      send(1'b0, 1'b1, 32'h12345678, '0);
      wait_done(300, n);
      check("stall_len", rx_log.size(), 7);
      for (int i = 0; i < 7 && i < rx_log.size(); i++) check("stall_byte", rx_log[i], lit_short[i]);
      rdy_mode = 0;
      tick(); tick();

      // start while busy (mid-frame and in the done cycle) is ignored
      rx_log.delete();
      send(1'b0, 1'b1, 32'h12345678, '0);
      tick(); tick();
      long_mode = 1'b1; nonce = 32'hDEADBEEF; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(50, n);
      long_mode = 1'b0; found = 1'b0; nonce = 32'hA5A5A5A5; start = 1'b1;
      tick();
      check("done_then_idle_busy", busy, 0);
      tick();
      start = 1'b0;
      check("restart_valid", tx_valid, 1);
      check("restart_sync", tx_data, 8'h5A);
      wait_done(50, n);
      check("restart_len", rx_log.size(), 14);
      for (int i = 0; i < 7 && i < rx_log.size(); i++) check("first_frame_byte", rx_log[i], lit_short[i]);
      for (int i = 0; i < 7 && i + 7 < rx_log.size(); i++) check("second_frame_byte", rx_log[i+7], lit_c[i]);
      tick();

      // Reset in the middle of the hash field, then a clean frame
      h6 = rand_hash();
      send(1'b1, 1'b1, $urandom, h6);
      n = 0;
      while (m_xfers < 16 && n < 100) begin
         tick();
         n++;
      end
      check("reach_hash10", m_xfers, 16);
      check("hash10_byte", tx_data, h6[87:80]);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_valid", tx_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", packet_done, 0);
      repeat (3) tick();
      rx_log.delete();
      send(1'b1, 1'b0, 32'hCAFEF00D, h6);
      wait_done(100, n);
      check("post_rst_len", rx_log.size(), 39);
      tick();

      // Randomized frames under random back-pressure
      rdy_mode = 1;
      for (int f = 0; f < 25; f++) begin
         send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, rand_hash());
         wait_done(400, n);
         repeat ($urandom_range(1, 3)) tick();
      end
      rdy_mode = 0;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/result_packet_encoder.md
Name: result_packet_encoder

Overview:
Transmit-side counterpart to the packet decoder path. Latches one mining result (nonce, optional 256-bit hash, found flag) and serialises it as a framed byte stream toward the host interface over a valid/ready byte handshake. Frame layout: sync, status, payload, XOR checksum. Signals frame completion with a one-cycle pulse.

Parameters:
SYNC_BYTE, 8'h5A, first byte of every frame
HASH_BYTES, 32, hash payload length in bytes for long frames; HASH_BYTES*8 is the hash port width

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  request to send one frame; sampled only in IDLE
long_mode  input  1  0 = short frame (nonce only), 1 = long frame (nonce + hash); latched on accepted start
found  input  1  golden-nonce flag; latched on accepted start
nonce  input  32  result nonce; latched on accepted start
hash  input  HASH_BYTES*8  result hash; latched on accepted start
tx_data  output  8  current frame byte
tx_valid  output  1  tx_data holds a valid byte
tx_ready  input  1  downstream accepts tx_data this cycle
busy  output  1  frame in progress; start ignored
packet_done  output  1  one-cycle pulse after the checksum byte is accepted

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). All state updates occur on the rising edge of clk.
- Reset: on any edge with rst=1, FSM goes to IDLE and tx_data=0, tx_valid=0, busy=0, packet_done=0. Latched fields and the checksum register clear to 0. Reset mid-frame aborts the frame with no packet_done, and rst takes priority over start.
- States: IDLE, SYNC, STATUS, NONCE, HASH, CSUM, DONE.
- IDLE: start=1 latches inputs and moves to SYNC. Next cycle: tx_valid=1, tx_data=SYNC_BYTE, busy=1. Latency from start to first valid byte is 1 cycle.
- Transfer: a byte moves only on a cycle with tx_valid=1 and tx_ready=1. While tx_valid=1 and tx_ready=0, tx_data is held stable. On a transfer, the next byte is presented on the next cycle, so back-to-back transfers give 1 byte/cycle.
- Frame byte order:
  - SYNC: SYNC_BYTE.
  - STATUS: {6'b0, long_mode_latched, found_latched}.
  - NONCE: 4 bytes, little-endian (nonce[7:0] first).
  - HASH: only if long_mode=1. HASH_BYTES bytes, hash[7:0] first.
  - CSUM: XOR of every preceding byte in the frame, including sync.
- Frame length: 7 bytes for short frames, 7+HASH_BYTES bytes (39 at default) for long frames.
- Byte index counter: 6-bit, cleared on every state entry. NONCE exits after index 3 transfers. HASH exits after index HASH_BYTES-1 transfers. No wrap is possible within a state.
- Checksum: running XOR register, cleared on accepted start, updated on each transferred byte from SYNC through HASH. CSUM presents the register value.
- CSUM transfer leads to DONE. DONE lasts 1 cycle: packet_done=1, tx_valid=0, busy=1. The FSM then returns to IDLE with busy=0, and start is accepted from that IDLE cycle onward.
- start while busy=1 (including DONE) is ignored and never queued. Input changes after latch do not affect the frame in flight.
- tx_valid is deasserted in IDLE and DONE only. Once asserted for a byte, it stays high until that byte transfers.
- packet_done never asserts for two consecutive cycles.

Test Plan:
1. Reset, then idle 5 cycles -> tx_valid=0, busy=0, packet_done=0 throughout.
2. nonce=32'h12345678, found=1, long_mode=0, start pulse, tx_ready=1 held -> bytes 5A 01 78 56 34 12 53 on 7 consecutive cycles; packet_done high exactly 1 cycle after the 0x53 transfer; then busy=0.
3. nonce=0, hash=0, found=0, long_mode=1, tx_ready=1 -> 39 bytes: 5A 02, then 36 bytes of 00, then checksum 58; packet_done pulses once.
4. Scenario 2 with tx_ready toggling 1,0,0,1,... pseudo-randomly -> same 7-byte sequence; tx_data stable during every stall cycle; no byte dropped or duplicated.
5. start re-pulsed mid-frame with different nonce and during DONE -> ignored; current frame unchanged; a start in the following IDLE cycle begins a new frame 1 cycle later.
6. rst asserted while in HASH at index 10 -> next cycle tx_valid=0, busy=0, no packet_done; a fresh start then produces a complete correct frame.
